riscv_mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline fields, performs word loads and stores over a req/gnt/rvalid data-memory bus, and stalls the upstream stages while an access is outstanding. It resolves conditional branches toward the fetch stage and registers the MEM/WB pipeline fields for write-back.

---
 rtl/riscv_mem_stage.sv | 155 +++++++++++++++
 tb/tb_riscv_mem_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: MEM stage of the 5-stage RISC-V pipeline.
// Issues word loads/stores on a req/gnt/rvalid bus, stalls upstream while an
// access is outstanding, resolves branches and registers the MEM/WB fields.
module riscv_mem_stage #(
    parameter  int XLEN          = 32,
    parameter  int REGFILE_COUNT = 32,
    localparam int RW            = $clog2(REGFILE_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            alu_zero_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] jp_addr_i,
    input  logic [RW-1:0]   rd_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            branch_i,
    output logic            stall_o,
    output logic            pc_src_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            valid_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic [XLEN-1:0] alu_out_o,
    output logic [RW-1:0]   rd_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic            mem_op, aligned, access, misaligned, rdata_cap;
    logic            valid_q, valid_d, mem_to_reg_q, mem_to_reg_d;
    logic            reg_write_q, reg_write_d, misalign_q, misalign_d;
    logic [XLEN-1:0] mem_rdata_q, mem_rdata_d, alu_out_q, alu_out_d;
    logic [RW-1:0]   rd_q, rd_d;

    assign mem_op     = valid_i & (mem_read_i | mem_write_i);
    assign aligned    = (alu_out_i[1:0] == 2'b00);
    assign access     = mem_op & aligned;
    assign misaligned = mem_op & ~aligned;

    // Bus fields are pure functions of the held EX/MEM inputs.
    assign dmem_addr_o     = {alu_out_i[XLEN-1:2], 2'b00};
    assign dmem_wdata_o    = rs2_data_i;
    assign dmem_we_o       = access & mem_write_i;
    assign dmem_be_o       = {4{dmem_we_o}};
    assign pc_src_o        = valid_i & branch_i & alu_zero_i;
    assign branch_target_o = jp_addr_i;

    // Access FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: stores finish on grant, loads wait for rvalid
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (access) state_d = dmem_gnt_i ? (mem_write_i ? IDLE : WAIT) : REQ;
            REQ:  if (dmem_gnt_i) state_d = mem_write_i ? IDLE : WAIT;
            WAIT: if (dmem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: request, stall and load-data capture strobe
    always_comb begin
        dmem_req_o = 1'b0;
        stall_o    = 1'b0;
        rdata_cap  = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req_o = access;
                stall_o    = access & ~(dmem_gnt_i & mem_write_i);
            end
            REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = ~(dmem_gnt_i & mem_write_i);
            end
            WAIT: begin
                stall_o   = ~dmem_rvalid_i;
                rdata_cap = dmem_rvalid_i;
            end
            default: ;
        endcase
    end

    // MEM/WB next values: advance when not stalled, else inject a bubble
    always_comb begin
        valid_d      = valid_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        misalign_d   = misalign_q;
        alu_out_d    = alu_out_q;
        rd_d         = rd_q;
        mem_rdata_d  = mem_rdata_q;
        if (!stall_o) begin
            valid_d      = valid_i;
            mem_to_reg_d = mem_to_reg_i;
            reg_write_d  = reg_write_i & ~misaligned;
            misalign_d   = misaligned;
            alu_out_d    = alu_out_i;
            rd_d         = rd_i;
        end else begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end
        if (rdata_cap) mem_rdata_d = dmem_rdata_i;
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            misalign_q   <= 1'b0;
            alu_out_q    <= '0;
            rd_q         <= '0;
            mem_rdata_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            misalign_q   <= misalign_d;
            alu_out_q    <= alu_out_d;
            rd_q         <= rd_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign valid_o      = valid_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign reg_write_o  = reg_write_q;
    assign misalign_o   = misalign_q;
    assign alu_out_o    = alu_out_q;
    assign rd_o         = rd_q;
    assign mem_rdata_o  = mem_rdata_q;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Bench for riscv_mem_stage: directed steps then random instructions, each
// checked against a transaction-level model (stall length from grant/rvalid
// delays, MEM/WB fields from the instruction itself).
module tb_riscv_mem_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0, rst;
    logic            valid_i, alu_zero_i, mem_to_reg_i, reg_write_i;
    logic            mem_read_i, mem_write_i, branch_i;
    logic [XLEN-1:0] alu_out_i, rs2_data_i, jp_addr_i, dmem_rdata_i;
    logic [RW-1:0]   rd_i;
    logic            dmem_gnt_i, dmem_rvalid_i;
    logic            stall_o, pc_src_o, dmem_req_o, dmem_we_o;
    logic [XLEN-1:0] branch_target_o, dmem_addr_o, dmem_wdata_o;
    logic [3:0]      dmem_be_o;
    logic            valid_o, mem_to_reg_o, reg_write_o, misalign_o;
    logic [XLEN-1:0] mem_rdata_o, alu_out_o;
    logic [RW-1:0]   rd_o;

    int              checks = 0, failures = 0;
    logic [XLEN-1:0] exp_rdata = '0;

    riscv_mem_stage #(.XLEN(XLEN), .REGFILE_COUNT(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .alu_zero_i(alu_zero_i),
        .alu_out_i(alu_out_i), .rs2_data_i(rs2_data_i), .jp_addr_i(jp_addr_i),
        .rd_i(rd_i), .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .branch_i(branch_i),
        .stall_o(stall_o), .pc_src_o(pc_src_o), .branch_target_o(branch_target_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_o(valid_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
        .misalign_o(misalign_o), .mem_rdata_o(mem_rdata_o), .alu_out_o(alu_out_o),
        .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        valid_i = 0; alu_zero_i = 0; mem_to_reg_i = 0; reg_write_i = 0;
        mem_read_i = 0; mem_write_i = 0; branch_i = 0;
        alu_out_i = '0; rs2_data_i = '0; jp_addr_i = '0; rd_i = '0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0;
    endtask

    // One instruction held in EX/MEM until it leaves the stage. dg = cycles from
    // first request to grant, dr = cycles from grant to rvalid (>=1).
    task automatic run_instr(input logic v, mr, mw, br, z, m2r, rw,
                             input logic [RW-1:0] rd, input logic [XLEN-1:0] alu, rs2, jp, rdat,
                             input int dg, dr);
        logic acc, mis, ld;
        int   total;
        acc   = v & (mr | mw) & (alu[1:0] == 2'b00);
        mis   = v & (mr | mw) & (alu[1:0] != 2'b00);
        ld    = acc & ~mw;
        total = !acc ? 0 : (mw ? dg : dg + dr);
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            valid_i = v; mem_read_i = mr; mem_write_i = mw; branch_i = br; alu_zero_i = z;
            mem_to_reg_i = m2r; reg_write_i = rw; rd_i = rd; alu_out_i = alu;
            rs2_data_i = rs2; jp_addr_i = jp;
            // stray grants while waiting and stray rvalids before grant must be ignored
            dmem_gnt_i    = (acc && k == dg) || (ld && k > dg);
            dmem_rvalid_i = ld && (k <= dg || k == dg + dr);
            dmem_rdata_i  = (k == dg + dr) ? rdat : ~rdat;
            #1;
            chk("stall", stall_o, k < total);
            chk("req", dmem_req_o, acc && k <= dg);
            chk("pc_src", pc_src_o, v & br & z);
            chk("target", branch_target_o, jp);
            if (acc && k <= dg) begin
                chk("addr", dmem_addr_o, {alu[31:2], 2'b00});
                chk("we", dmem_we_o, mw);
                chk("wdata", dmem_wdata_o, rs2);
                chk("be", dmem_be_o, mw ? 4'hF : 4'h0);
            end
            @(posedge clk); #1;
            if (k < total) begin
                chk("bubble_valid", valid_o, 1'b0);
                chk("bubble_rw", reg_write_o, 1'b0);
            end
        end
        if (ld) exp_rdata = rdat;
        chk("wb_valid", valid_o, v);
        chk("wb_rd", rd_o, rd);
        chk("wb_alu", alu_out_o, alu);
        chk("wb_m2r", mem_to_reg_o, m2r);
        chk("wb_rw", reg_write_o, rw & ~mis);
        chk("wb_mis", misalign_o, mis);
        chk("wb_rdata", mem_rdata_o, exp_rdata);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", valid_o, 0);   chk("rst_rw", reg_write_o, 0);
        chk("rst_m2r", mem_to_reg_o, 0); chk("rst_mis", misalign_o, 0);
        chk("rst_rdata", mem_rdata_o, 0); chk("rst_alu", alu_out_o, 0);
        chk("rst_rd", rd_o, 0);          chk("rst_stall", stall_o, 0);
        rst = 0;

        // ALU op
        run_instr(1, 0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 1);
        // store, granted immediately
        run_instr(1, 0, 1, 0, 0, 0, 0, 5'd0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1);
        // load, grant after 2, rvalid 3 after grant -> 5 stall cycles
        run_instr(1, 1, 0, 0, 0, 1, 1, 5'd7, 32'h200, 0, 0, 32'hCAFEF00D, 2, 3);
        // misaligned load
        run_instr(1, 1, 0, 0, 0, 1, 1, 5'd9, 32'h202, 0, 0, 32'h0, 0, 1);
        // branches taken / not taken
        run_instr(1, 0, 0, 1, 1, 0, 0, 5'd0, 32'h0, 0, 32'h40, 0, 0, 1);
        run_instr(1, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 0, 32'h40, 0, 0, 1);
        // delayed store
        run_instr(1, 0, 1, 0, 0, 0, 0, 5'd0, 32'h104, 32'h0BADF00D, 0, 0, 0, 3);

        // reset during WAIT, late rvalid dropped
        @(negedge clk);
        valid_i = 1; mem_read_i = 1; alu_out_i = 32'h300; rd_i = 5'd3; reg_write_i = 1;
        dmem_gnt_i = 1;
        @(negedge clk);
        dmem_gnt_i = 0;
        #1 chk("wait_stall", stall_o, 1);
        @(negedge clk);
        rst = 1; idle_inputs();
        #1;
        chk("rstw_stall", stall_o, 0); chk("rstw_req", dmem_req_o, 0);
        chk("rstw_valid", valid_o, 0);
        exp_rdata = '0;
        @(negedge clk);
        rst = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h55;
        @(posedge clk); #1;
        chk("late_rvalid_rdata", mem_rdata_o, exp_rdata);
        chk("late_rvalid_valid", valid_o, 0);
        chk("late_rvalid_stall", stall_o, 0);
        @(negedge clk);
        dmem_rvalid_i = 0;

        // random instructions
        for (int i = 0; i < 60; i++) begin
            logic [XLEN-1:0] a;
            logic mr, mw;
            int kind;
            kind = $urandom_range(0, 3);
            mr = (kind == 1); mw = (kind == 2);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_instr($urandom_range(0, 7) != 0, mr, mw, kind == 3, 1'($urandom),
                      1'($urandom), 1'($urandom), 5'($urandom), a, $urandom, $urandom,
                      $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
